// File: rtl/io_pkg.sv
// Shared definitions for the Reduceron I/O UART transmitter: the write address map,
// the TX state encoding, and the line level that goes with each state.
package io_pkg;

  localparam logic [13:0] TX_ADDR   = 14'h0000;
  localparam logic [13:0] LED_ADDR  = 14'h0001;
  localparam logic [13:0] CTRL_ADDR = 14'h0002;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Serial line level for a state; only DATA depends on the shifted byte.
  function automatic logic line_level(input tx_state_e st, input logic data_bit);
    case (st)
      ST_START: line_level = 1'b0;
      ST_DATA:  line_level = data_bit;
      default:  line_level = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with extra-MSB wrapping pointers; the head entry is read
// combinationally so a pop and its data land on the same edge.
module io_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign rdata = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, an LED register and a
// sticky overflow flag, driven from the Reduceron I/O write bus.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        iowrite,
  input  logic [13:0] ioaddr,
  input  logic [13:0] iowd,
  output logic        uart_txd,
  output logic [13:0] leds,
  output logic        fifo_full,
  output logic        overflow,
  output logic        tx_idle
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic [13:0]       leds_q, leds_d;
  logic              overflow_q, overflow_d;

  logic              tx_wr, led_wr, ctrl_wr;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [7:0]        fifo_rdata;
  logic              bit_done;

  io_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (iowd[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tx_wr   = iowrite && (ioaddr == TX_ADDR);
    led_wr  = iowrite && (ioaddr == LED_ADDR);
    ctrl_wr = iowrite && (ioaddr == CTRL_ADDR);
  end

  assign bit_done = (baud_q == '0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = BAUD_RELOAD;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d    = BAUD_RELOAD;
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) state_d = ST_IDLE;
        else          baud_d  = baud_q - BAUD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    txd_d      = line_level(state_q, shift_q[0]);
    fifo_push  = tx_wr && (!fifo_full || fifo_pop);
    leds_d     = led_wr ? iowd : leds_q;
    overflow_d = overflow_q;
    if (tx_wr && !fifo_push)     overflow_d = 1'b1;
    else if (ctrl_wr && iowd[0]) overflow_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      leds_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= txd_d;
      leds_q     <= leds_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    shift_q <= shift_d;
  end

  assign uart_txd = txd_q;
  assign leds     = leds_q;
  assign overflow = overflow_q;
  assign tx_idle  = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed scenarios plus random bus traffic, checked every
// cycle against a queue-and-timeline model of the transmitter and a line decoder.
module tb_io_uart_tx;

  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        iowrite  = 1'b0;
  logic [13:0] ioaddr   = '0;
  logic [13:0] iowd     = '0;
  logic        uart_txd;
  logic [13:0] leds;
  logic        fifo_full;
  logic        overflow;
  logic        tx_idle;

  io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .iowrite   (iowrite),
    .ioaddr    (ioaddr),
    .iowd      (iowd),
    .uart_txd  (uart_txd),
    .leds      (leds),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .tx_idle   (tx_idle)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;

  // Model: queued bytes, the edge of the last pop and the byte it took.
  int          q[$];
  int          last_pop   = -100000;
  logic [7:0]  frame_byte = '0;
  logic        ovf_m      = 1'b0;
  logic [13:0] leds_m     = '0;

  // Line decoder: frame start edges and decoded bytes.
  int          starts[$];
  int          rx_q[$];
  int          rx_cnt  = 0;
  logic [7:0]  rx_byte = '0;
  logic        prev_txd = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    logic [9:0] fr;
    k  = edge_no - last_pop - 1;
    fr = {1'b1, frame_byte, 1'b0};
    if (k >= 0 && k < FRAME) return fr[k / C];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    int k;
    k = edge_no - last_pop;
    return (k >= 0 && k < FRAME);
  endfunction

  task automatic model_edge(input logic rst_n, input logic wr, input logic [13:0] a, input logic [13:0] d);
    bit pop, push;
    pop = 0; push = 0;
    if (!rst_n) begin
      q.delete();
      last_pop = -100000;
      ovf_m    = 1'b0;
      leds_m   = '0;
    end else begin
      pop = (q.size() > 0) && (edge_no >= last_pop + FRAME + 1);
      if (wr) begin
        if (a == 14'h0000) begin
          if (q.size() < D || pop) push = 1;
          else                     ovf_m = 1'b1;
        end else if (a == 14'h0001) begin
          leds_m = d;
        end else if (a == 14'h0002 && d[0]) begin
          ovf_m = 1'b0;
        end
      end
      if (pop) begin
        frame_byte = 8'(q.pop_front());
        last_pop   = edge_no;
      end
      if (push) q.push_back(int'(d[7:0]));
    end
  endtask

  task automatic rx_sample();
    if (rx_cnt == 0) begin
      if (prev_txd == 1'b1 && uart_txd == 1'b0) begin
        rx_cnt  = 1;
        rx_byte = '0;
        starts.push_back(edge_no);
      end
    end else begin
      for (int i = 0; i < 8; i++)
        if (rx_cnt == (i + 1) * C + C / 2 - 1) rx_byte[i] = uart_txd;
      if (rx_cnt == 9 * C + C / 2 - 1) begin
        rx_q.push_back(int'(rx_byte));
        rx_cnt = 0;
      end else begin
        rx_cnt++;
      end
    end
    prev_txd = uart_txd;
  endtask

  task automatic step(input logic rst_n, input logic wr, input logic [13:0] a, input logic [13:0] d);
    RESET_N = rst_n;
    iowrite = wr;
    ioaddr  = a;
    iowd    = d;
    @(posedge CLOCK_50);
    edge_no++;
    model_edge(rst_n, wr, a, d);
    #1;
    chk("uart_txd", {31'd0, uart_txd}, {31'd0, exp_txd()});
    chk("tx_idle", {31'd0, tx_idle}, {31'd0, (q.size() == 0) && !exp_busy()});
    chk("fifo_full", {31'd0, fifo_full}, {31'd0, q.size() == D});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    chk("leds", {18'd0, leds}, {18'd0, leds_m});
    rx_sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 14'h0000, 14'h0000);
  endtask

  task automatic wr(input logic [13:0] a, input logic [13:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() > 0 || exp_busy() || rx_cnt != 0) && guard < 3000) begin
      idle(1);
      guard++;
    end
    idle(2);
    chk("drain_bound", {31'd0, guard < 3000}, 32'd1);
  endtask

  initial begin
    int n_wr, n_rst_at, guard;
    logic [13:0] ra;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 14'h0000, 14'h0000);
    chk("reset_txd", {31'd0, uart_txd}, 32'd1);
    chk("reset_idle", {31'd0, tx_idle}, 32'd1);
    chk("reset_full", {31'd0, fifo_full}, 32'd0);
    idle(3);

    // Single byte 0xA5
    starts.delete(); rx_q.delete();
    n_wr = edge_no + 1;
    wr(14'h0000, 14'h00A5);
    drain();
    chk("single_frames", starts.size(), 32'd1);
    if (starts.size() >= 1) chk("single_latency", starts[0] - n_wr, 32'd2);
    if (rx_q.size() >= 1)   chk("single_byte", rx_q[0], 32'hA5);

    // Burst of six: five sent, sixth dropped
    starts.delete(); rx_q.delete();
    for (int i = 1; i <= 6; i++) wr(14'h0000, 14'(i));
    chk("burst_ovf", {31'd0, overflow}, 32'd1);
    idle(10);
    // Clearing overflow mid-frame leaves the frame untouched
    wr(14'h0002, 14'h0001);
    chk("ovf_clear", {31'd0, overflow}, 32'd0);
    drain();
    chk("burst_frames", rx_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("burst_byte", rx_q[i], i + 1);
    for (int i = 0; i + 1 < starts.size(); i++) chk("burst_period", starts[i + 1] - starts[i], FRAME + 1);

    // LED register and an unmapped address
    wr(14'h0001, 14'h2AAA);
    chk("led_write", {18'd0, leds}, 32'h2AAA);
    wr(14'h3FFF, 14'h1234);
    chk("led_unmapped", {18'd0, leds}, 32'h2AAA);
    chk("unmapped_idle", {31'd0, tx_idle}, 32'd1);

    // Full FIFO with a push on the pop edge
    for (int i = 0; i < 5; i++) wr(14'h0000, 14'h0040 + 14'(i));
    chk("fill_full", {31'd0, fifo_full}, 32'd1);
    guard = 0;
    while (edge_no + 1 < last_pop + FRAME + 1 && guard < 200) begin idle(1); guard++; end
    chk("swap_bound", {31'd0, guard < 200}, 32'd1);
    wr(14'h0000, 14'h0099);
    chk("swap_ovf", {31'd0, overflow}, 32'd0);
    chk("swap_full", {31'd0, fifo_full}, 32'd1);
    drain();

    // Reset during DATA bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) wr(14'h0000, 14'h00F0 + 14'(i));
    guard = 0;
    while (edge_no < last_pop + 4 * C && guard < 200) begin idle(1); guard++; end
    step(1'b0, 1'b1, 14'h0000, 14'h0077);
    chk("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
    chk("rst_mid_idle", {31'd0, tx_idle}, 32'd1);
    step(1'b0, 1'b1, 14'h0001, 14'h0155);
    n_rst_at = starts.size();
    idle(3 * (FRAME + 1));
    chk("rst_no_frames", starts.size() - n_rst_at, 32'd0);
    chk("rst_leds", {18'd0, leds}, 32'd0);

    // Random traffic, including occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1'b0, 1'($urandom_range(0, 1)), 14'h0000, 14'($urandom));
      end else if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: ra = 14'h0000;
          3:       ra = 14'h0001;
          4:       ra = 14'h0002;
          default: ra = 14'($urandom_range(3, 16383));
        endcase
        wr(ra, 14'($urandom));
      end else begin
        idle(1);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
